// File: rtl/interleaver_block_scheduler_pkg.sv
// Shared constants and types for the turbo interleaver block scheduler.
// Block sizes are in bytes; counters are sized to hold the largest block without wrapping.
package turbo_pkg;

    localparam int unsigned SMALL_BYTES     = 132;
    localparam int unsigned LARGE_BYTES     = 768;
    localparam int unsigned DEF_TIMEOUT_CYC = 4096;
    localparam int unsigned CNT_W           = 10;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} sched_state_t;

    function automatic logic [CNT_W-1:0] blk_bytes(input logic cbs);
        return cbs ? CNT_W'(LARGE_BYTES) : CNT_W'(SMALL_BYTES);
    endfunction

endpackage

// File: rtl/interleaver_block_scheduler_if.sv
// Requester, interleaver and status signals of the block scheduler.
// master is the scheduler's view; slave is the surrounding environment.
interface interleaver_block_scheduler_if;

    logic       req0_vld;
    logic       req0_cbs;
    logic [7:0] req0_data;
    logic       req0_rdy;
    logic       req1_vld;
    logic       req1_cbs;
    logic [7:0] req1_data;
    logic       req1_rdy;
    logic       il_vld_crc;
    logic       il_cbs;
    logic [7:0] il_data_in;
    logic       il_rdy_crc;
    logic       il_vld_out;
    logic       il_last_byte;
    logic       busy;
    logic       grant_id;
    logic       blk_done;
    logic       err;

    modport master (
        input  req0_vld, req0_cbs, req0_data, req1_vld, req1_cbs, req1_data,
        input  il_rdy_crc, il_vld_out, il_last_byte,
        output req0_rdy, req1_rdy, il_vld_crc, il_cbs, il_data_in,
        output busy, grant_id, blk_done, err
    );

    modport slave (
        output req0_vld, req0_cbs, req0_data, req1_vld, req1_cbs, req1_data,
        output il_rdy_crc, il_vld_out, il_last_byte,
        input  req0_rdy, req1_rdy, il_vld_crc, il_cbs, il_data_in,
        input  busy, grant_id, blk_done, err
    );

endinterface

// File: rtl/interleaver_block_scheduler_arb.sv
// Two-way round-robin arbiter; remembers the last requester served.
// Reset leaves requester 1 as last served so requester 0 wins the first contest.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served_id,
    output logic       gnt_vld,
    output logic       gnt_id
);

    logic last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= served_id;
        end
    end

    always_comb begin
        gnt_vld = |req;
        gnt_id  = (&req) ? ~last_q : req[1];
    end

endmodule

// File: rtl/interleaver_block_scheduler.sv
// Shares one turbo interleaver between two CRC-stage requesters, one code block at a time:
// grant, load blk_len bytes, wait for the drain to end on last_byte, then release.
module interleaver_block_scheduler
    import turbo_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input logic                           clk,
    input logic                           reset,
    interleaver_block_scheduler_if.master bus
);

    localparam int unsigned IdleW = $clog2(TIMEOUT_CYC);

    sched_state_t     state_q, state_d;
    logic             grant_id_q, grant_id_d;
    logic             cbs_q, cbs_d;
    logic [CNT_W-1:0] blk_len_q, blk_len_d;
    logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;
    logic [CNT_W-1:0] dr_cnt_q, dr_cnt_d;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    logic             arb_vld, arb_id;
    logic             in_load, timeout, abort;

    // Last-served advances on clean completion and on any abort alike.
    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       ({bus.req1_vld, bus.req0_vld}),
        .update    ((state_q == DONE) | abort),
        .served_id (grant_id_q),
        .gnt_vld   (arb_vld),
        .gnt_id    (arb_id)
    );

    assign in_load = (state_q == LOAD);
    assign timeout = (idle_cnt_q == IdleW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        cbs_d      = cbs_q;
        blk_len_d  = blk_len_q;
        ld_cnt_d   = ld_cnt_q;
        dr_cnt_d   = dr_cnt_q;
        idle_cnt_d = idle_cnt_q;
        abort      = 1'b0;
        unique case (state_q)
            IDLE: begin
                ld_cnt_d   = '0;
                dr_cnt_d   = '0;
                idle_cnt_d = '0;
                if (arb_vld) begin
                    grant_id_d = arb_id;
                    cbs_d      = arb_id ? bus.req1_cbs : bus.req0_cbs;
                    blk_len_d  = blk_bytes(cbs_d);
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (bus.il_last_byte) begin
                    abort = 1'b1;
                end else if (bus.il_rdy_crc) begin
                    idle_cnt_d = '0;
                    ld_cnt_d   = ld_cnt_q + CNT_W'(1);
                    if (ld_cnt_q == blk_len_q - CNT_W'(1)) state_d = DRAIN;
                end else if (timeout) begin
                    abort = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + IdleW'(1);
                end
            end
            DRAIN: begin
                if (bus.il_vld_out) begin
                    idle_cnt_d = '0;
                    dr_cnt_d   = dr_cnt_q + CNT_W'(1);
                    if (bus.il_last_byte) begin
                        if (dr_cnt_q == blk_len_q - CNT_W'(1)) state_d = DONE;
                        else abort = 1'b1;
                    end else if (dr_cnt_q >= blk_len_q) begin
                        abort = 1'b1;
                    end
                end else if (timeout) begin
                    abort = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + IdleW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_id_q <= 1'b0;
            cbs_q      <= 1'b0;
            blk_len_q  <= '0;
            ld_cnt_q   <= '0;
            dr_cnt_q   <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            cbs_q      <= cbs_d;
            blk_len_q  <= blk_len_d;
            ld_cnt_q   <= ld_cnt_d;
            dr_cnt_q   <= dr_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.il_vld_crc = in_load;
    assign bus.il_cbs     = cbs_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.blk_done   = (state_q == DONE);
    assign bus.err        = abort;
    assign bus.il_data_in = in_load ? (grant_id_q ? bus.req1_data : bus.req0_data) : 8'h00;
    assign bus.req0_rdy   = in_load & ~grant_id_q & bus.il_rdy_crc;
    assign bus.req1_rdy   = in_load & grant_id_q & bus.il_rdy_crc;

endmodule

// File: tb/tb_interleaver_block_scheduler.sv
// Randomized scoreboard bench: block order and payload predicted from round-robin rules.
module tb_interleaver_block_scheduler;
    import turbo_pkg::*;

    typedef struct packed {bit cbs; bit [7:0] seed;} job_t;
    typedef struct packed {bit id; bit cbs; bit [7:0] seed; bit ok;} exp_t;

    logic       clk;
    logic       reset;
    logic       rq_vld [2];
    logic       rq_cbs [2];
    logic [7:0] rq_data[2];
    job_t       jobq0[$];
    job_t       jobq1[$];
    exp_t       exp_q[$];
    int         n_cmp;
    int         n_bad;
    bit         chk_en;
    bit         exp_last;
    bit         stall_arm;
    bit         early_arm;

    interleaver_block_scheduler_if ifc();

    interleaver_block_scheduler #(.TIMEOUT_CYC(DEF_TIMEOUT_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    assign ifc.req0_vld  = rq_vld[0];
    assign ifc.req0_cbs  = rq_cbs[0];
    assign ifc.req0_data = rq_data[0];
    assign ifc.req1_vld  = rq_vld[1];
    assign ifc.req1_cbs  = rq_cbs[1];
    assign ifc.req1_data = rq_data[1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] data_of(input logic [7:0] seed, input int idx);
        return seed ^ 8'((idx * 37) + (idx >> 3));
    endfunction

    function automatic int blen(input bit cbs);
        return cbs ? 768 : 132;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Queue jobs for both requesters and predict completion order from round-robin rules.
    task automatic plan(input int n0, input int n1, input bit first_ok, input int cbs_mode);
        job_t j0[$];
        job_t j1[$];
        job_t j;
        exp_t e;
        int   i0;
        int   i1;
        bit   first;
        for (int i = 0; i < n0 + n1; i++) begin
            j.seed = 8'($urandom);
            if (cbs_mode == 2) j.cbs = ($urandom_range(0, 3) == 0);
            else j.cbs = (cbs_mode == 1);
            if (i < n0) j0.push_back(j);
            else j1.push_back(j);
        end
        i0 = 0;
        i1 = 0;
        first = 1'b1;
        while (i0 < n0 || i1 < n1) begin
            if (i0 < n0 && i1 < n1) e.id = !exp_last;
            else e.id = (i1 < n1);
            j = e.id ? j1[i1] : j0[i0];
            if (e.id) i1++;
            else i0++;
            e.cbs  = j.cbs;
            e.seed = j.seed;
            e.ok   = first ? first_ok : 1'b1;
            first  = 1'b0;
            exp_q.push_back(e);
            exp_last = e.id;
        end
        foreach (j0[i]) jobq0.push_back(j0[i]);
        foreach (j1[i]) jobq1.push_back(j1[i]);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((exp_q.size() != 0 || jobq0.size() != 0 || jobq1.size() != 0 || ifc.busy)
                   && k < budget);
        check("blocks_outstanding", exp_q.size(), 0);
    endtask

    // Requester: holds vld and presents bytes until its block ends, then takes the next job.
    task automatic drive_req(input int r);
        job_t job;
        bit   got;
        bit   beat;
        bit   fin;
        int   idx;
        forever begin
            got = 1'b0;
            if (r == 0 && jobq0.size() > 0) begin
                job = jobq0.pop_front();
                got = 1'b1;
            end else if (r == 1 && jobq1.size() > 0) begin
                job = jobq1.pop_front();
                got = 1'b1;
            end
            if (!got) begin
                @(posedge clk);
                #1;
            end else begin
                idx        = 0;
                rq_vld[r]  = 1'b1;
                rq_cbs[r]  = job.cbs;
                rq_data[r] = data_of(job.seed, 0);
                fin        = 1'b0;
                while (!fin) begin
                    @(negedge clk);
                    beat = (r == 0) ? ifc.req0_rdy : ifc.req1_rdy;
                    fin  = (ifc.blk_done || ifc.err) && (ifc.grant_id == r[0]);
                    @(posedge clk);
                    #1;
                    if (beat) begin
                        idx++;
                        rq_cbs[r] = 1'($urandom);
                    end
                    rq_data[r] = data_of(job.seed, idx);
                end
                rq_vld[r] = 1'b0;
            end
        end
    endtask

    initial drive_req(0);
    initial drive_req(1);

    // Interleaver model: random load back-pressure, random drain pacing, last on final byte.
    initial begin
        int ld_n;
        int dr_n;
        int cur_len;
        bit draining;
        bit ld_b;
        bit dr_b;
        bit lst;
        bit e;
        ld_n = 0;
        dr_n = 0;
        cur_len = 132;
        draining = 1'b0;
        ifc.il_rdy_crc = 1'b0;
        ifc.il_vld_out = 1'b0;
        ifc.il_last_byte = 1'b0;
        forever begin
            @(negedge clk);
            ld_b = ifc.il_vld_crc && ifc.il_rdy_crc;
            dr_b = ifc.il_vld_out;
            lst  = ifc.il_last_byte;
            e    = ifc.err;
            if (ld_b && ld_n == 0) cur_len = ifc.il_cbs ? 768 : 132;
            @(posedge clk);
            #1;
            if (!reset || e) begin
                ld_n = 0;
                dr_n = 0;
                draining = 1'b0;
                if (e) begin
                    stall_arm = 1'b0;
                    early_arm = 1'b0;
                end
            end else begin
                if (ld_b) begin
                    ld_n++;
                    if (ld_n == cur_len) begin
                        draining = 1'b1;
                        ld_n = 0;
                        dr_n = 0;
                    end
                end
                if (dr_b) begin
                    dr_n++;
                    if (lst) draining = 1'b0;
                end
            end
            ifc.il_rdy_crc   = !(stall_arm && ld_n >= 20) && ($urandom_range(0, 3) != 0);
            ifc.il_vld_out   = draining && ($urandom_range(0, 3) != 0);
            ifc.il_last_byte = ifc.il_vld_out && (dr_n + 1 == (early_arm ? 100 : cur_len));
        end
    end

    // Monitor: checks every load beat and every block end against the expected-block queue.
    initial begin
        int   ld_idx;
        bit   exp_drop;
        bit   exp_idle;
        exp_t h;
        ld_idx = 0;
        exp_drop = 1'b0;
        exp_idle = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset || !chk_en) begin
                ld_idx = 0;
                exp_drop = 1'b0;
                exp_idle = 1'b0;
            end else begin
                if (exp_drop) begin
                    check("vld_crc_drop", int'(ifc.il_vld_crc), 0);
                    exp_drop = 1'b0;
                end
                if (exp_idle) begin
                    check("busy_after_err", int'(ifc.busy), 0);
                    exp_idle = 1'b0;
                end
                if (ifc.il_vld_crc && ifc.il_rdy_crc) begin
                    check("load_has_pending_block", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        h = exp_q[0];
                        if (ld_idx == 0) begin
                            check("grant_id", int'(ifc.grant_id), int'(h.id));
                            check("il_cbs", int'(ifc.il_cbs), int'(h.cbs));
                        end
                        check("load_byte", int'(ifc.il_data_in), int'(data_of(h.seed, ld_idx)));
                        ld_idx++;
                        if (ld_idx == blen(h.cbs)) exp_drop = 1'b1;
                    end
                end
                if (ifc.blk_done || ifc.err) begin
                    check("end_has_pending_block", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        h = exp_q.pop_front();
                        check("end_grant_id", int'(ifc.grant_id), int'(h.id));
                        check("end_cbs", int'(ifc.il_cbs), int'(h.cbs));
                        check("end_blk_done", int'(ifc.blk_done), int'(h.ok));
                        check("end_err", int'(ifc.err), int'(!h.ok));
                        if (h.ok) check("load_count", ld_idx, blen(h.cbs));
                        if (ifc.err) exp_idle = 1'b1;
                        ld_idx = 0;
                    end
                end
            end
        end
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: got no finish, expected finish within 80000 cycles");
        $fatal(1);
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(ifc.busy), 0);
        check({tag, "_il_vld_crc"}, int'(ifc.il_vld_crc), 0);
        check({tag, "_il_cbs"}, int'(ifc.il_cbs), 0);
        check({tag, "_grant_id"}, int'(ifc.grant_id), 0);
        check({tag, "_blk_done"}, int'(ifc.blk_done), 0);
        check({tag, "_err"}, int'(ifc.err), 0);
        check({tag, "_req0_rdy"}, int'(ifc.req0_rdy), 0);
        check({tag, "_req1_rdy"}, int'(ifc.req1_rdy), 0);
        check({tag, "_il_data_in"}, int'(ifc.il_data_in), 0);
    endtask

    initial begin
        int k;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        chk_en = 1'b1;
        exp_last = 1'b1;
        stall_arm = 1'b0;
        early_arm = 1'b0;
        for (int r = 0; r < 2; r++) begin
            rq_vld[r] = 1'b0;
            rq_cbs[r] = 1'b0;
            rq_data[r] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        @(negedge clk);
        reset = 1'b1;

        @(negedge clk); plan(3, 3, 1'b1, 2); wait_idle(20000);
        @(negedge clk); plan(0, 1, 1'b1, 1); wait_idle(5000);
        @(negedge clk); plan(1, 0, 1'b1, 0); wait_idle(2000);
        @(negedge clk); stall_arm = 1'b1; plan(1, 2, 1'b0, 0); wait_idle(12000);
        @(negedge clk); early_arm = 1'b1; plan(1, 0, 1'b0, 0); wait_idle(2000);

        // Reset in the middle of a large load, outside scoreboard control.
        @(negedge clk);
        chk_en = 1'b0;
        rq_cbs[1] = 1'b1;
        rq_vld[1] = 1'b1;
        k = 0;
        while (!ifc.busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("midload_granted", int'(ifc.busy), 1);
        repeat (20) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midload_rst");
        repeat (2) @(posedge clk);
        #1;
        rq_vld[1] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_last = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;

        @(negedge clk); plan(1, 1, 1'b1, 0); wait_idle(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
